pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 4-stage pipeline (IF, IF/ID, ID/EX, EX/WB).
- Resolves branch and jump outcomes arriving at the WB stage.
- Detects read-after-write hazards: no forwarding path exists, so dependent instructions wait in ID.
- Drives PC select/hold and per-buffer hold and flush enables so each pipeline buffer either advances, holds, or loads a bubble (all control bits 0).

Parameters:
REG_W, 6, register index width (matches rd field).
FLUSH_CYCLES, 3, bubble cycles after a taken branch/jump (1..7).
CNT_W, 16, perf counter width (optional feature only).

Ports:
clk  in  1  system clock, all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
wb_branch  in  1  EX/WB out_ctrl_branch.
wb_btype  in  1  EX/WB branch type: 0 = branch-if-zero, 1 = branch-if-negative.
wb_jump  in  1  EX/WB out_ctrl_jump.
wb_zero  in  1  EX/WB out_ctrl_zero.
wb_neg  in  1  EX/WB out_ctrl_neg.
id_rs  in  REG_W  source reg 1 of instruction in IF/ID.
id_rt  in  REG_W  source reg 2 of instruction in IF/ID.
id_uses_rt  in  1  instruction in IF/ID reads rt.
ex_regwrt  in  1  ID/EX regwrite.
ex_rd  in  REG_W  ID/EX destination.
wb_regwrt  in  1  EX/WB regwrite.
wb_rd  in  REG_W  EX/WB destination.
pc_sel  out  1  1 = load branch/jump target into PC.
pc_hold  out  1  PC keeps value.
ifid_hold  out  1  IF/ID keeps contents.
ifid_flush  out  1  IF/ID loads bubble.
idex_flush  out  1  ID/EX loads bubble.
exwb_flush  out  1  EX/WB loads bubble.
busy  out  1  state != RUN.

Behaviour:
- States:
  - INIT: entered on reset.
  - RUN.
  - STALL.
  - FLUSH: holds 3-bit counter fcnt.
- Reset (rst_n low, immediate): state = INIT, fcnt = 0. Combinational outputs are then pc_sel = 0, pc_hold = 1, all flush = 1, ifid_hold = 0, busy = 1.
- INIT: one cycle of full flush, then RUN.
- taken = wb_jump | (wb_branch & (wb_btype ? wb_neg : wb_zero)).
- hazard:
  - Raised when a producer's regwrt = 1, its rd != 0, and rd equals id_rs, or equals id_rt when id_uses_rt = 1.
  - Producers: ex (ex_regwrt, ex_rd) and wb (wb_regwrt, wb_rd).
  - Register 0 is never a hazard.
- RUN, Mealy outputs, same cycle:
  - taken: pc_sel = 1, all three flush = 1. Next state FLUSH with fcnt = FLUSH_CYCLES - 1.
  - else hazard: pc_hold = 1, ifid_hold = 1, idex_flush = 1. Next state STALL.
  - else: all outputs 0.
- STALL:
  - Same outputs as a RUN hazard cycle while hazard persists.
  - Return to RUN in the first cycle hazard = 0; outputs that cycle are all 0, so IF/ID advances.
  - taken in STALL overrides the stall exactly as in RUN.
- FLUSH:
  - idex_flush = 1 and exwb_flush = 1. pc_sel = 0, pc_hold = 0, ifid_flush = 0.
  - taken and hazard inputs are ignored: they come from bubbles.
  - fcnt decrements each cycle; go to RUN when fcnt == 0.
  - FLUSH_CYCLES = 1 gives a single flush cycle with no FLUSH dwell.
- Priority: reset > taken > hazard.
- All flush outputs are 0 in RUN with no event.
- Reset asserted mid-FLUSH or mid-STALL aborts to INIT immediately.

Optional Feature:
PIPE_PERF_CNT_EN:
- When defined, adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W].
  - stall_cnt increments every cycle pc_hold = 1 due to a hazard.
  - flush_cnt increments once per taken event.
  - Both saturate at all-ones and reset to 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset release -> exactly 1 cycle of all flush = 1, pc_hold = 1, then RUN with all outputs 0 and busy = 0.
2. wb_branch = 1, wb_btype = 0, wb_zero = 1 in RUN -> pc_sel = 1 plus 3 flushes that cycle, then 2 cycles of idex/exwb flush (FLUSH_CYCLES = 3), then RUN.
3. wb_branch = 1, wb_btype = 1, wb_neg = 0, wb_zero = 1 -> not taken; all outputs 0.
4. ex_regwrt = 1, ex_rd = 5, id_rs = 5 -> pc_hold = ifid_hold = idex_flush = 1. Producer moves to WB (wb_rd = 5) -> stall continues. wb_regwrt drops -> RUN, outputs 0.
5. Hazard on rd = 0, or on rt with id_uses_rt = 0 -> no stall.
6. Stall active and wb_jump = 1 simultaneously -> pc_sel = 1 and taken-flush pattern. rst_n pulsed low mid-FLUSH -> outputs go to reset values asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 4-stage pipeline branch/hazard sequencing controller
// Optional perf counters under `PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int REG_W        = 6,
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_branch,
  input  logic             wb_btype,
  input  logic             wb_jump,
  input  logic             wb_zero,
  input  logic             wb_neg,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_regwrt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             wb_regwrt,
  input  logic [REG_W-1:0] wb_rd,
  output logic             pc_sel,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exwb_flush,
  output logic             busy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_STALL,
    S_FLUSH
  } state_t;

  localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       taken;
  logic       ex_hit;
  logic       wb_hit;
  logic       hazard;

  assign taken = wb_jump | (wb_branch & (wb_btype ? wb_neg : wb_zero));

  // No forwarding: any in-flight writer of a source register blocks ID.
  assign ex_hit = ex_regwrt && (ex_rd != '0) &&
                  ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign wb_hit = wb_regwrt && (wb_rd != '0) &&
                  ((wb_rd == id_rs) || (id_uses_rt && (wb_rd == id_rt)));
  assign hazard = ex_hit | wb_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pc_sel     = 1'b0;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exwb_flush = 1'b0;
    case (state_q)
      S_INIT: begin
        pc_hold    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exwb_flush = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (taken) begin
          pc_sel     = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          exwb_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            fcnt_d  = FCNT_LOAD;
          end else begin
            state_d = S_RUN;
            fcnt_d  = 3'd0;
          end
        end else if (hazard) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_flush = 1'b1;
          state_d    = S_STALL;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        // Branch/hazard inputs here come from bubbles and are ignored.
        idex_flush = 1'b1;
        exwb_flush = 1'b1;
        fcnt_d     = fcnt_q - 3'd1;
        if (fcnt_q <= 3'd1) begin
          state_d = S_RUN;
          fcnt_d  = 3'd0;
        end
      end
      default: begin
        state_d = S_INIT;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  assign busy = (state_q != S_RUN);

`ifdef PIPE_PERF_CNT_EN
  logic resolving;
  logic stall_evt;
  logic flush_evt;

  assign resolving = (state_q == S_RUN) || (state_q == S_STALL);
  assign flush_evt = resolving && taken;
  assign stall_evt = resolving && !taken && hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
// Define PIPE_PERF_CNT_EN to also check the perf counters.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 6;
  localparam int CNT_W = 16;

  // {pc_sel, pc_hold, ifid_hold, ifid_flush, idex_flush, exwb_flush, busy}
  localparam logic [6:0] O_INIT        = 7'b0101111;
  localparam logic [6:0] O_RUN         = 7'b0000000;
  localparam logic [6:0] O_TAKEN_RUN   = 7'b1001110;
  localparam logic [6:0] O_TAKEN_STALL = 7'b1001111;
  localparam logic [6:0] O_HAZ_RUN     = 7'b0110100;
  localparam logic [6:0] O_HAZ_STALL   = 7'b0110101;
  localparam logic [6:0] O_STALL_EXIT  = 7'b0000001;
  localparam logic [6:0] O_FLUSH       = 7'b0000111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wb_branch, wb_btype, wb_jump, wb_zero, wb_neg;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd, wb_rd;
  logic             id_uses_rt, ex_regwrt, wb_regwrt;
  logic             pc_sel, pc_hold, ifid_hold, ifid_flush, idex_flush, exwb_flush, busy;
  logic [6:0]       obs;
  int               checks = 0;
  int               errors = 0;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_branch  (wb_branch),
    .wb_btype   (wb_btype),
    .wb_jump    (wb_jump),
    .wb_zero    (wb_zero),
    .wb_neg     (wb_neg),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_regwrt  (ex_regwrt),
    .ex_rd      (ex_rd),
    .wb_regwrt  (wb_regwrt),
    .wb_rd      (wb_rd),
    .pc_sel     (pc_sel),
    .pc_hold    (pc_hold),
    .ifid_hold  (ifid_hold),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .exwb_flush (exwb_flush),
    .busy       (busy)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  assign obs = {pc_sel, pc_hold, ifid_hold, ifid_flush, idex_flush, exwb_flush, busy};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] expv);
    #1;
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] o, input logic [CNT_W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
`endif

  task automatic clear_in();
    wb_branch = 0; wb_btype = 0; wb_jump = 0; wb_zero = 0; wb_neg = 0;
    id_rs = '0; id_rt = '0; id_uses_rt = 0;
    ex_regwrt = 0; ex_rd = '0; wb_regwrt = 0; wb_rd = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    tick();
    chk("reset_state", O_INIT);
    rst_n = 1'b1;
    chk("init_after_release", O_INIT);
    tick();
    chk("run_after_init", O_RUN);

    // Taken branch-if-zero, then two FLUSH cycles, then RUN.
    wb_branch = 1; wb_btype = 0; wb_zero = 1;
    chk("beqz_taken", O_TAKEN_RUN);
    tick();
    chk("flush_1_ignores_branch", O_FLUSH);
    clear_in();
    tick();
    chk("flush_2", O_FLUSH);
    tick();
    chk("run_after_flush", O_RUN);

    // Branch-if-negative with neg=0 is not taken even though zero=1.
    wb_branch = 1; wb_btype = 1; wb_neg = 0; wb_zero = 1;
    chk("bneg_not_taken", O_RUN);
    clear_in();

    // EX producer hazard, then WB producer, then release.
    ex_regwrt = 1; ex_rd = 6'd5; id_rs = 6'd5;
    chk("ex_hazard_run", O_HAZ_RUN);
    tick();
    ex_regwrt = 0; ex_rd = '0; wb_regwrt = 1; wb_rd = 6'd5;
    chk("wb_hazard_stall", O_HAZ_STALL);
    tick();
    wb_regwrt = 0;
    chk("stall_exit", O_STALL_EXIT);
    tick();
    chk("run_after_stall", O_RUN);

    // Non-hazards: rd=0, and rt match with id_uses_rt=0.
    ex_regwrt = 1; ex_rd = '0; id_rs = '0;
    chk("rd0_no_hazard", O_RUN);
    ex_rd = 6'd7; id_rs = 6'd3; id_rt = 6'd7; id_uses_rt = 0;
    chk("rt_unused_no_hazard", O_RUN);
    id_uses_rt = 1;
    chk("rt_hazard_run", O_HAZ_RUN);
    tick();

    // Jump while stalled overrides the stall.
    wb_jump = 1;
    chk("jump_in_stall", O_TAKEN_STALL);
    tick();
    wb_jump = 0;
    chk("flush_ignores_hazard", O_FLUSH);
`ifdef PIPE_PERF_CNT_EN
    chk_cnt("stall_cnt", stall_cnt, 16'd3);
    chk_cnt("flush_cnt", flush_cnt, 16'd2);
`endif

    // Asynchronous reset in the middle of FLUSH.
    rst_n = 1'b0;
    chk("reset_mid_flush", O_INIT);
`ifdef PIPE_PERF_CNT_EN
    chk_cnt("stall_cnt_reset", stall_cnt, 16'd0);
    chk_cnt("flush_cnt_reset", flush_cnt, 16'd0);
`endif
    clear_in();
    tick();
    rst_n = 1'b1;
    chk("init_after_reset2", O_INIT);
    tick();
    chk("run_after_reset2", O_RUN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
